// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter and its source FIFOs.
package cdb_arbiter_pkg;

  // ROB tag width; tag value 0 is reserved for "no producer".
  localparam int Q_WIDTH = 4;

  // Reserved tag meaning "operand ready / no producer".
  localparam logic [Q_WIDTH-1:0] TAG_NONE = {Q_WIDTH{1'b0}};

  // Source index used by the grant logic and the round-robin history.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_SLB = 1'b1
  } src_e;

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_src_fifo.sv
// Small skid FIFO holding results from one execution source until the
// arbiter grants them onto the common data bus.
module cdb_src_fifo #(
  parameter int Q_WIDTH    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic               en,
  input  logic [Q_WIDTH-1:0] in_tag,
  input  logic [31:0]        in_value,
  output logic [Q_WIDTH-1:0] out_tag,
  output logic [31:0]        out_value,
  output logic               head_valid,
  output logic               ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [Q_WIDTH-1:0] tag_q   [FIFO_DEPTH];
  logic [Q_WIDTH-1:0] tag_d   [FIFO_DEPTH];
  logic [31:0]        value_q [FIFO_DEPTH];
  logic [31:0]        value_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push;
  logic               do_pop;

  // Status and head outputs come from registered state only.
  always_comb begin
    ready      = (count_q != CNT_FULL);
    head_valid = (count_q != CNT_ZERO);
    out_tag    = tag_q[rd_ptr_q];
    out_value  = value_q[rd_ptr_q];
  end

  // Next-state: flush beats push/pop; pointers wrap naturally (depth is 2^n).
  always_comb begin
    tag_d    = tag_q;
    value_d  = value_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_FULL);
    do_pop   = pop && (count_q != CNT_ZERO);
    if (!en) begin
      count_d = count_q;
    end else if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      if (do_push) begin
        tag_d[wr_ptr_q]   = in_tag;
        value_d[wr_ptr_q] = in_value;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_q[i]   <= {Q_WIDTH{1'b0}};
        value_q[i] <= 32'd0;
      end
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      tag_q    <= tag_d;
      value_q  <= value_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : cdb_src_fifo

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and load/store results and
// broadcasts one per cycle, round-robin between the two sources.
module cdb_arbiter #(
  parameter int Q_WIDTH    = cdb_arbiter_pkg::Q_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               control_hazard,
  input  logic               alu_valid,
  input  logic [Q_WIDTH-1:0] alu_rob_tag,
  input  logic [31:0]        alu_value,
  output logic               alu_ready,
  input  logic               slb_valid,
  input  logic [Q_WIDTH-1:0] slb_rob_tag,
  input  logic [31:0]        slb_value,
  output logic               slb_ready,
  output logic               cdb_valid,
  output logic [Q_WIDTH-1:0] cdb_rob_tag,
  output logic [31:0]        cdb_value
);

  import cdb_arbiter_pkg::*;

  localparam logic [Q_WIDTH-1:0] TAG_NULL = Q_WIDTH'(TAG_NONE);

  logic               alu_push, alu_pop, alu_head_valid;
  logic               slb_push, slb_pop, slb_head_valid;
  logic [Q_WIDTH-1:0] alu_head_tag, slb_head_tag;
  logic [31:0]        alu_head_value, slb_head_value;
  logic               grant_valid;
  src_e               grant_src;
  src_e               last_grant_q, last_grant_d;

  cdb_src_fifo #(
    .Q_WIDTH    (Q_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (alu_push),
    .pop        (alu_pop),
    .flush      (control_hazard),
    .en         (rdy_in),
    .in_tag     (alu_rob_tag),
    .in_value   (alu_value),
    .out_tag    (alu_head_tag),
    .out_value  (alu_head_value),
    .head_valid (alu_head_valid),
    .ready      (alu_ready)
  );

  cdb_src_fifo #(
    .Q_WIDTH    (Q_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_slb_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (slb_push),
    .pop        (slb_pop),
    .flush      (control_hazard),
    .en         (rdy_in),
    .in_tag     (slb_rob_tag),
    .in_value   (slb_value),
    .out_tag    (slb_head_tag),
    .out_value  (slb_head_value),
    .head_valid (slb_head_valid),
    .ready      (slb_ready)
  );

  // Accept offers only with a real tag; tag 0 offers are silently dropped.
  always_comb begin
    alu_push = alu_valid && alu_ready && (alu_rob_tag != TAG_NULL);
    slb_push = slb_valid && slb_ready && (slb_rob_tag != TAG_NULL);
  end

  // Round-robin grant: on a tie, the source that did not win last time goes.
  always_comb begin
    grant_valid = alu_head_valid || slb_head_valid;
    grant_src   = SRC_ALU;
    if (alu_head_valid && slb_head_valid) begin
      grant_src = (last_grant_q == SRC_ALU) ? SRC_SLB : SRC_ALU;
    end else if (slb_head_valid) begin
      grant_src = SRC_SLB;
    end else begin
      grant_src = SRC_ALU;
    end
  end

  // Broadcast, pop and round-robin history update.
  always_comb begin
    cdb_valid    = grant_valid && rdy_in && !control_hazard;
    cdb_rob_tag  = TAG_NULL;
    cdb_value    = 32'd0;
    alu_pop      = 1'b0;
    slb_pop      = 1'b0;
    last_grant_d = last_grant_q;
    if (cdb_valid) begin
      last_grant_d = grant_src;
      case (grant_src)
        SRC_ALU: begin
          cdb_rob_tag = alu_head_tag;
          cdb_value   = alu_head_value;
          alu_pop     = 1'b1;
        end
        SRC_SLB: begin
          cdb_rob_tag = slb_head_tag;
          cdb_value   = slb_head_value;
          slb_pop     = 1'b1;
        end
        default: begin
          cdb_rob_tag = TAG_NULL;
          cdb_value   = 32'd0;
        end
      endcase
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin history; reset to SLB so the ALU wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= SRC_SLB;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        control_hazard;
  logic        alu_valid;
  logic [3:0]  alu_rob_tag;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        slb_valid;
  logic [3:0]  slb_rob_tag;
  logic [31:0] slb_value;
  logic        slb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_tag;
  logic [31:0] cdb_value;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.Q_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .control_hazard (control_hazard),
    .alu_valid      (alu_valid),
    .alu_rob_tag    (alu_rob_tag),
    .alu_value      (alu_value),
    .alu_ready      (alu_ready),
    .slb_valid      (slb_valid),
    .slb_rob_tag    (slb_rob_tag),
    .slb_value      (slb_value),
    .slb_ready      (slb_ready),
    .cdb_valid      (cdb_valid),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_value      (cdb_value)
  );

  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge (drive point).
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Let combinational outputs settle, still well before the next edge.
  task automatic settle;
    #2;
  endtask

  task automatic clear_inputs;
    control_hazard = 1'b0;
    alu_valid = 1'b0; alu_rob_tag = 4'd0; alu_value = 32'd0;
    slb_valid = 1'b0; slb_rob_tag = 4'd0; slb_value = 32'd0;
  endtask

  // Apply reset for one edge; returns at the drive point of the first free cycle.
  task automatic do_reset;
    clear_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    settle();
    total++;
    if (alu_ready !== 1'b1 || slb_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got alu=%0b slb=%0b want 1 1", alu_ready, slb_ready);
    end
    total++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== 4'd0 || cdb_value !== 32'd0) begin
      bad++;
      $display("FAIL reset_cdb: got v=%0b tag=%0d val=%h want 0 0 0", cdb_valid, cdb_rob_tag, cdb_value);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd3; alu_value = 32'h11;
    settle();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_no_bypass: got v=%0b want 0", cdb_valid);
    end
    tick();
    clear_inputs();
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd3 || cdb_value !== 32'h11) begin
      bad++;
      $display("FAIL single_bcast: got v=%0b tag=%0d val=%h want 1 3 11", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
    settle();
    total++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== 4'd0 || cdb_value !== 32'd0) begin
      bad++;
      $display("FAIL single_idle: got v=%0b tag=%0d val=%h want 0 0 0", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
  endtask

  task automatic test_tie;
    logic [3:0] first_tag, second_tag;
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd2; alu_value = 32'h22;
    slb_valid = 1'b1; slb_rob_tag = 4'd5; slb_value = 32'h55;
    settle();
    tick();
    clear_inputs();
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd2 || cdb_value !== 32'h22) begin
      bad++;
      $display("FAIL tie_first: got v=%0b tag=%0d val=%h want 1 2 22", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd5 || cdb_value !== 32'h55) begin
      bad++;
      $display("FAIL tie_second: got v=%0b tag=%0d val=%h want 1 5 55", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
    // Six ties, each preceded by a single broadcast that sets the history:
    // SLB prelude -> ALU wins the tie, ALU prelude -> SLB wins the tie.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        slb_valid = 1'b1; slb_rob_tag = 4'd9; slb_value = 32'h99;
        first_tag = 4'd2; second_tag = 4'd5;
      end else begin
        alu_valid = 1'b1; alu_rob_tag = 4'd9; alu_value = 32'h99;
        first_tag = 4'd5; second_tag = 4'd2;
      end
      settle();
      tick();
      clear_inputs();
      settle();
      total++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd9) begin
        bad++;
        $display("FAIL tie_prelude[%0d]: got v=%0b tag=%0d want 1 9", i, cdb_valid, cdb_rob_tag);
      end
      tick();
      alu_valid = 1'b1; alu_rob_tag = 4'd2; alu_value = 32'h22;
      slb_valid = 1'b1; slb_rob_tag = 4'd5; slb_value = 32'h55;
      settle();
      tick();
      clear_inputs();
      settle();
      total++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== first_tag) begin
        bad++;
        $display("FAIL tie_rr_first[%0d]: got v=%0b tag=%0d want 1 %0d", i, cdb_valid, cdb_rob_tag, first_tag);
      end
      tick();
      settle();
      total++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== second_tag) begin
        bad++;
        $display("FAIL tie_rr_second[%0d]: got v=%0b tag=%0d want 1 %0d", i, cdb_valid, cdb_rob_tag, second_tag);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  a_list [4];
    logic [3:0]  s_list [3];
    logic [3:0]  exp_tag [7];
    logic [31:0] exp_val [7];
    int ia, is, nb;
    logic a_acc, s_acc, seen_drop;
    a_list  = '{4'd10, 4'd11, 4'd12, 4'd13};
    s_list  = '{4'd1, 4'd2, 4'd3};
    exp_tag = '{4'd10, 4'd1, 4'd11, 4'd2, 4'd12, 4'd3, 4'd13};
    exp_val = '{32'h100A, 32'h2001, 32'h100B, 32'h2002, 32'h100C, 32'h2003, 32'h100D};
    ia = 0; is = 0; nb = 0; seen_drop = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      alu_valid   = (ia < 4);
      alu_rob_tag = (ia < 4) ? a_list[ia] : 4'd0;
      alu_value   = 32'h1000 + 32'(alu_rob_tag);
      slb_valid   = (is < 3);
      slb_rob_tag = (is < 3) ? s_list[is] : 4'd0;
      slb_value   = 32'h2000 + 32'(slb_rob_tag);
      settle();
      a_acc = alu_valid && alu_ready;
      s_acc = slb_valid && slb_ready;
      if (!seen_drop && slb_ready === 1'b0) begin
        seen_drop = 1'b1;
        total++;
        if (is != 2 || slb_valid !== 1'b1 || slb_rob_tag !== 4'd3) begin
          bad++;
          $display("FAIL full_drop: got accepts=%0d held_tag=%0d want 2 3", is, slb_rob_tag);
        end
      end
      if (cdb_valid === 1'b1) begin
        total++;
        if (nb >= 7) begin
          bad++;
          $display("FAIL full_extra: got tag=%0d want no broadcast", cdb_rob_tag);
        end else if (cdb_rob_tag !== exp_tag[nb] || cdb_value !== exp_val[nb]) begin
          bad++;
          $display("FAIL full_order[%0d]: got tag=%0d val=%h want %0d %h", nb, cdb_rob_tag, cdb_value, exp_tag[nb], exp_val[nb]);
        end
        nb++;
      end
      tick();
      if (a_acc) ia++;
      if (s_acc) is++;
    end
    clear_inputs();
    total++;
    if (nb != 7 || !seen_drop || is != 3 || ia != 4) begin
      bad++;
      $display("FAIL full_count: got bcasts=%0d drop=%0b slb_acc=%0d alu_acc=%0d want 7 1 3 4", nb, seen_drop, is, ia);
    end
  endtask

  task automatic test_flush;
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd1; alu_value = 32'h1;
    slb_valid = 1'b1; slb_rob_tag = 4'd4; slb_value = 32'h4;
    settle();
    tick();
    alu_rob_tag = 4'd2; alu_value = 32'h2;
    slb_rob_tag = 4'd5; slb_value = 32'h5;
    settle();
    tick();
    clear_inputs();
    control_hazard = 1'b1;
    alu_valid = 1'b1; alu_rob_tag = 4'd7; alu_value = 32'h7;
    settle();
    total++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== 4'd0) begin
      bad++;
      $display("FAIL flush_cycle: got v=%0b tag=%0d want 0 0", cdb_valid, cdb_rob_tag);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      settle();
      total++;
      if (cdb_valid !== 1'b0 || cdb_rob_tag === 4'd7 || alu_ready !== 1'b1 || slb_ready !== 1'b1) begin
        bad++;
        $display("FAIL flush_after[%0d]: got v=%0b tag=%0d rdy=%0b%0b want 0 0 11", c, cdb_valid, cdb_rob_tag, alu_ready, slb_ready);
      end
      tick();
    end
  endtask

  task automatic test_stall_reset;
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd6; alu_value = 32'h66;
    slb_valid = 1'b1; slb_rob_tag = 4'd8; slb_value = 32'h88;
    settle();
    tick();
    clear_inputs();
    rdy_in = 1'b0;
    alu_valid = 1'b1; alu_rob_tag = 4'd12; alu_value = 32'hCC;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (cdb_valid !== 1'b0 || alu_ready !== 1'b1 || slb_ready !== 1'b1) begin
        bad++;
        $display("FAIL stall[%0d]: got v=%0b rdy=%0b%0b want 0 11", c, cdb_valid, alu_ready, slb_ready);
      end
      tick();
    end
    clear_inputs();
    rdy_in = 1'b1;
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd6 || cdb_value !== 32'h66) begin
      bad++;
      $display("FAIL stall_resume: got v=%0b tag=%0d val=%h want 1 6 66", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd8 || cdb_value !== 32'h88) begin
      bad++;
      $display("FAIL stall_second: got v=%0b tag=%0d val=%h want 1 8 88", cdb_valid, cdb_rob_tag, cdb_value);
    end
    tick();
    settle();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_push: got v=%0b tag=%0d want 0", cdb_valid, cdb_rob_tag);
    end
    tick();
    // Mid-stream reset: queue work, then reset with a grant pending.
    alu_valid = 1'b1; alu_rob_tag = 4'd1; alu_value = 32'h1;
    slb_valid = 1'b1; slb_rob_tag = 4'd2; slb_value = 32'h2;
    settle();
    tick();
    clear_inputs();
    alu_valid = 1'b1; alu_rob_tag = 4'd3; alu_value = 32'h3;
    settle();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd1) begin
      bad++;
      $display("FAIL midreset_pre: got v=%0b tag=%0d want 1 1", cdb_valid, cdb_rob_tag);
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    clear_inputs();
    settle();
    total++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== 4'd0 || cdb_value !== 32'd0 || alu_ready !== 1'b1 || slb_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_out: got v=%0b tag=%0d val=%h rdy=%0b%0b want 0 0 0 11", cdb_valid, cdb_rob_tag, cdb_value, alu_ready, slb_ready);
    end
    tick();
    settle();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_empty: got v=%0b tag=%0d want 0", cdb_valid, cdb_rob_tag);
    end
    tick();
  endtask

  task automatic test_tag0;
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd0; alu_value = 32'hDEAD;
    settle();
    tick();
    alu_rob_tag = 4'd0;
    settle();
    total++;
    if (cdb_valid !== 1'b0 || alu_ready !== 1'b1) begin
      bad++;
      $display("FAIL tag0_first: got v=%0b rdy=%0b want 0 1", cdb_valid, alu_ready);
    end
    tick();
    clear_inputs();
    settle();
    total++;
    if (cdb_valid !== 1'b0 || alu_ready !== 1'b1) begin
      bad++;
      $display("FAIL tag0_second: got v=%0b rdy=%0b want 0 1", cdb_valid, alu_ready);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    test_tag0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cdb_arbiter

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the execution units and the reservation station, load/store buffer and ROB. It collects results from the ALU path and the load/store buffer, each through a small skid FIFO. It grants one result per cycle onto a single broadcast port using round-robin between the two sources, so each consumer needs only one tag comparator per operand slot. On a control hazard it discards all buffered results.

## Interface
- Q_WIDTH, 4, ROB tag width; tag 0 is reserved and means "operand ready / no producer".
- FIFO_DEPTH, 2, entries per source FIFO; must be a power of two, minimum 2.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous and active-high.
- rdy_in  input  1  global enable; when low, all state holds.
- control_hazard  input  1  flush; clears both FIFOs.
- alu_valid  input  1  ALU result offered.
- alu_rob_tag  input  Q_WIDTH  destination ROB tag.
- alu_value  input  32  result value.
- alu_ready  output  1  ALU FIFO can accept.
- slb_valid  input  1  load/store result offered.
- slb_rob_tag  input  Q_WIDTH  destination ROB tag.
- slb_value  input  32  result value.
- slb_ready  output  1  SLB FIFO can accept.
- cdb_valid  output  1  broadcast valid this cycle.
- cdb_rob_tag  output  Q_WIDTH  broadcast tag.
- cdb_value  output  32  broadcast value.

## Operation
- Each source has its own FIFO: a storage array, a read pointer, a write pointer and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Accept: push when x_valid && x_ready && x_rob_tag != 0. An offer with tag 0 is silently dropped, and ready is not affected.
- x_ready = (count_x != FIFO_DEPTH). It is computed from the registered count only; a same-cycle pop does not raise it.
- Grant (combinational, from the FIFO heads):
  - If only one head is valid, that source is granted.
  - If both are valid, the source not recorded in last_grant is granted.
  - If neither is valid, there is no grant.
- Broadcast: cdb_valid = grant && rdy_in && !control_hazard. cdb_rob_tag and cdb_value come from the granted head.
- When cdb_valid is low, cdb_rob_tag and cdb_value are driven to 0.
- Pop: the granted FIFO pops on the edge where cdb_valid = 1, and last_grant is updated to that source.
- Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance.
- control_hazard (with rdy_in high): both counts and all pointers go to 0, and that cycle's pushes are discarded. last_grant is kept.
- rdy_in low: no push, no pop, no pointer or last_grant change. cdb_valid is 0. Ready outputs still reflect the held counts.
- Reset:
  - Counts and pointers are 0 and last_grant = SLB, so the ALU wins the first tie.
  - Outputs: alu_ready = 1, slb_ready = 1, cdb_valid = 0, cdb_rob_tag = 0, cdb_value = 0.
  - rst_in takes priority over rdy_in and control_hazard.

## Timing
- Latency: a result accepted at edge N appears on the CDB in cycle N+1 at the earliest. There is no same-cycle bypass.
- Sustained throughput: one broadcast per cycle in total. Under continuous contention each source gets one grant every 2 cycles.
- Backpressure: a producer sees x_ready low in the cycle after its FIFO fills. It must hold valid, tag and value until it samples x_ready = 1.
- The outputs are combinational from registers only. There is no path from inputs to outputs except through rdy_in and control_hazard gating cdb_valid.

## Structure
- A shared package holds Q_WIDTH, the reserved tag value TAG_NONE = 0, and the source-index constants SRC_ALU = 0 and SRC_SLB = 1.
- Sub-module cdb_src_fifo is instantiated twice. Its parameters are Q_WIDTH and FIFO_DEPTH. Its ports are push, pop, flush, en, the tag/value in and out, head_valid and ready.
- The grant logic and the last_grant register live in the top-level block.

## Test plan
- Single source: ALU offers tag 3, value 0x11 at cycle 1 -> cdb_valid=1, tag 3, value 0x11 in cycle 2; idle in cycle 3.
- Tie after reset: ALU tag 2 and SLB tag 5 are pushed in the same cycle -> CDB shows tag 2, then tag 5, on consecutive cycles. Repeating the tie then yields the order 5 before 2 only if last_grant = ALU (check alternation over 6 ties).
- Full FIFO: SLB pushes 3 results (tags 1, 2, 3) back to back while the ALU FIFO is kept non-empty:
  - slb_ready drops after 2 accepts.
  - The third offer is held until ready.
  - All three tags are eventually broadcast in order.
- Flush: 2 entries are queued per FIFO and control_hazard is raised for one cycle together with an ALU push of tag 7 -> cdb_valid=0 that cycle; there are no broadcasts afterwards, tag 7 never appears, and both ready signals = 1.
- Stall and reset: rdy_in is held low for 3 cycles with entries queued -> no broadcasts and counts held; the broadcast resumes on the first cycle with rdy_in high. Asserting rst_in mid-stream -> all outputs take their reset values the next cycle.
- Tag 0: ALU offers tag 0 -> no push, no broadcast, alu_ready stays 1.
